// File: rtl/core_memory_pkg.sv
// core_memory_pkg: shared constants and types for the core_memory block.
//   NOP_INSTR   - instruction returned to the core while it is held off
//   mem_state_e - boot-load / run state encoding
package core_memory_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    MEM_LOAD = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/core_memory_mem_array.sv
// mem_array: unified word array with one byte-strobed synchronous write port
// and two registered read ports.
//   clk        rising-edge clock
//   we_i       write enable
//   waddr_i    write word index
//   wdata_i    write data
//   wbe_i      byte write strobes (tie all-ones for full-word writes)
//   raddr_a_i  port A word index (write-first: forwards the merged write word)
//   rdata_a_o  port A read data, one cycle after the address
//   raddr_b_i  port B word index (read-first: returns the pre-write contents)
//   rdata_b_o  port B read data, one cycle after the address
// The array has no reset; contents survive a block reset.
module mem_array
  import core_memory_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN/8-1:0] wbe_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [XLEN-1:0]   rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [XLEN-1:0]   rdata_b_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_a_q;
  logic [XLEN-1:0] rdata_b_q;
  logic [XLEN-1:0] wmerged;

  // Word as it will look after this cycle's write; used for port A forwarding.
  always_comb begin
    wmerged = mem_q[waddr_i];
    for (int b = 0; b < XLEN / 8; b++) begin
      if (wbe_i[b]) wmerged[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN / 8; b++) begin
      if (we_i && wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
    if (we_i && (raddr_a_i == waddr_i)) rdata_a_q <= wmerged;
    else                                rdata_a_q <= mem_q[raddr_a_i];
    rdata_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/core_memory.sv
// core_memory: memory responder for the core's instruction and data ports,
// with a boot-load FSM that fills the array from a valid/ready stream.
//   clk, rst_n          clock, synchronous active-low reset
//   instr_addr/_rdata   fetch port (read-only, 1-cycle latency)
//   data_we/_addr/_wdata/_rdata  data port (write-first, 1-cycle latency)
//   load_valid/_ready/_data/_last  boot stream
//   core_run            high once loading is done
//   data_be             byte strobes, only when CORE_MEMORY_BYTE_STROBE_EN
//                       is defined; otherwise every write is a full word
//
// state    | meaning
// MEM_LOAD | accepting boot words; core sees NOPs and zero read data
// MEM_RUN  | core ports serviced; boot stream ignored
module core_memory
  import core_memory_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   instr_addr,
  output logic [31:0]       instr_rdata,
  input  logic              data_we,
  input  logic [XLEN-1:0]   data_addr,
  input  logic [XLEN-1:0]   data_wdata,
  output logic [XLEN-1:0]   data_rdata,
`ifdef CORE_MEMORY_BYTE_STROBE_EN
  input  logic [XLEN/8-1:0] data_be,
`endif
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [XLEN-1:0]   load_data,
  input  logic              load_last,
  output logic              core_run
);

  mem_state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic ready_q;
  logic rd_valid_q;
  logic load_fire;

  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [XLEN-1:0]   arr_wdata;
  logic [XLEN/8-1:0] arr_wbe;
  logic [XLEN/8-1:0] run_be;
  logic [XLEN-1:0]   arr_rdata_a;
  logic [XLEN-1:0]   arr_rdata_b;

  wire [AW-1:0] instr_idx = instr_addr[AW+1:2];
  wire [AW-1:0] data_idx  = data_addr[AW+1:2];

  // Low byte-offset bits and high alias bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[1:0], instr_addr[XLEN-1:AW+2],
                              data_addr[1:0], data_addr[XLEN-1:AW+2]};

`ifdef CORE_MEMORY_BYTE_STROBE_EN
  assign run_be = data_be;
`else
  assign run_be = '1;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    load_fire = 1'b0;
    case (state_q)
      MEM_LOAD: begin
        if (load_valid && ready_q) begin
          load_fire = 1'b1;
          ptr_d     = ptr_q + 1'b1;
          if (load_last || (&ptr_q)) state_d = MEM_RUN;
        end
      end
      MEM_RUN: state_d = MEM_RUN;
      default: state_d = MEM_LOAD;
    endcase
  end

  // Write port mux; writes are suppressed in a reset cycle so a reset
  // asserted mid-RUN cannot corrupt the retained contents.
  always_comb begin
    arr_waddr = ptr_q;
    arr_wdata = load_data;
    arr_wbe   = '1;
    arr_we    = load_fire && rst_n;
    if (state_q == MEM_RUN) begin
      arr_waddr = data_idx;
      arr_wdata = data_wdata;
      arr_wbe   = run_be;
      arr_we    = data_we && rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= MEM_LOAD;
      ptr_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ready_q    <= (state_d == MEM_LOAD);
      // Array read registers hold a RUN-cycle read only one cycle after
      // the FSM is in RUN; until then outputs are forced.
      rd_valid_q <= (state_q == MEM_RUN);
    end
  end

  mem_array #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk       (clk),
    .we_i      (arr_we),
    .waddr_i   (arr_waddr),
    .wdata_i   (arr_wdata),
    .wbe_i     (arr_wbe),
    .raddr_a_i (data_idx),
    .rdata_a_o (arr_rdata_a),
    .raddr_b_i (instr_idx),
    .rdata_b_o (arr_rdata_b)
  );

  assign instr_rdata = rd_valid_q ? arr_rdata_b[31:0] : NOP_INSTR;
  assign data_rdata  = rd_valid_q ? arr_rdata_a : '0;
  assign load_ready  = ready_q;
  assign core_run    = (state_q == MEM_RUN);

endmodule

// File: tb/tb_core_memory.sv
module tb_core_memory;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: default depth 1024
  logic        rst0_n = 1'b0;
  logic [31:0] i_addr0 = '0, d_addr0 = '0, d_wdata0 = '0, l_data0 = '0;
  logic        d_we0 = 1'b0, l_valid0 = 1'b0, l_last0 = 1'b0;
  logic [31:0] i_rdata0, d_rdata0;
  logic        l_ready0, run0;
`ifdef CORE_MEMORY_BYTE_STROBE_EN
  logic [3:0]  d_be0 = 4'hF;
  logic [3:0]  d_be1 = 4'hF;
`endif

  // Instance 1: depth 4, exercises the array-full exit
  logic        rst1_n = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0, l_data1 = '0;
  logic        d_we1 = 1'b0, l_valid1 = 1'b0, l_last1 = 1'b0;
  logic [31:0] i_rdata1, d_rdata1;
  logic        l_ready1, run1;

  core_memory #(.XLEN(32), .DEPTH_WORDS(1024)) dut0 (
    .clk         (clk),
    .rst_n       (rst0_n),
    .instr_addr  (i_addr0),
    .instr_rdata (i_rdata0),
    .data_we     (d_we0),
    .data_addr   (d_addr0),
    .data_wdata  (d_wdata0),
    .data_rdata  (d_rdata0),
`ifdef CORE_MEMORY_BYTE_STROBE_EN
    .data_be     (d_be0),
`endif
    .load_valid  (l_valid0),
    .load_ready  (l_ready0),
    .load_data   (l_data0),
    .load_last   (l_last0),
    .core_run    (run0)
  );

  core_memory #(.XLEN(32), .DEPTH_WORDS(4)) dut1 (
    .clk         (clk),
    .rst_n       (rst1_n),
    .instr_addr  (i_addr1),
    .instr_rdata (i_rdata1),
    .data_we     (d_we1),
    .data_addr   (d_addr1),
    .data_wdata  (d_wdata1),
    .data_rdata  (d_rdata1),
`ifdef CORE_MEMORY_BYTE_STROBE_EN
    .data_be     (d_be1),
`endif
    .load_valid  (l_valid1),
    .load_ready  (l_ready1),
    .load_data   (l_data1),
    .load_last   (l_last1),
    .core_run    (run1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] boot0 [4];
  logic [31:0] boot1 [4];

  initial begin
    boot0[0] = 32'h11; boot0[1] = 32'h22; boot0[2] = 32'h33; boot0[3] = 32'h44;
    boot1[0] = 32'hA0; boot1[1] = 32'hA1; boot1[2] = 32'hA2; boot1[3] = 32'hA3;

    // ---------------- reset state ----------------
    step(); step();
    check_eq("rst_core_run",   {31'b0, run0},     32'h0);
    check_eq("rst_load_ready", {31'b0, l_ready0}, 32'h0);
    check_eq("rst_instr",      i_rdata0,          NOP);
    check_eq("rst_data",       d_rdata0,          32'h0);

    // ---------------- LOAD with core-side activity ----------------
    rst0_n = 1'b1;
    i_addr0 = 32'h0; d_we0 = 1'b1; d_addr0 = 32'h4; d_wdata0 = 32'hDEAD;
    step();
    check_eq("load_ready_up",  {31'b0, l_ready0}, 32'h1);
    check_eq("load_instr_nop", i_rdata0,          NOP);
    check_eq("load_data_zero", d_rdata0,          32'h0);

    for (int i = 0; i < 4; i++) begin
      l_valid0 = 1'b1; l_data0 = boot0[i]; l_last0 = (i == 3);
      step();
      if (i == 1) begin
        // a stalled beat must not advance the pointer
        l_valid0 = 1'b0; l_data0 = 32'hBAD0BAD0;
        step();
        check_eq("stall_run", {31'b0, run0}, 32'h0);
      end
      if (i == 2) check_eq("pre_last_run", {31'b0, run0}, 32'h0);
    end
    l_valid0 = 1'b0; l_last0 = 1'b0; d_we0 = 1'b0;
    check_eq("run_rise",       {31'b0, run0},     32'h1);
    check_eq("ready_drop",     {31'b0, l_ready0}, 32'h0);
    check_eq("first_run_nop",  i_rdata0,          NOP);

    // ---------------- RUN reads ----------------
    i_addr0 = 32'h0; d_addr0 = 32'h4;
    step();
    check_eq("fetch_0",        i_rdata0, 32'h11);
    check_eq("word1_kept",     d_rdata0, 32'h22);
    i_addr0 = 32'h8; d_addr0 = 32'hC;
    step();
    check_eq("fetch_8",        i_rdata0, 32'h33);
    check_eq("data_c",         d_rdata0, 32'h44);

    // ---------------- same-cycle collision ----------------
    d_we0 = 1'b1; d_addr0 = 32'h10; d_wdata0 = 32'h55; i_addr0 = 32'h0;
    step();
    check_eq("wr_first_fwd",   d_rdata0, 32'h55);
    d_wdata0 = 32'hCAFEBABE; i_addr0 = 32'h10;
    step();
    check_eq("coll_data_new",  d_rdata0, 32'hCAFEBABE);
    check_eq("coll_instr_old", i_rdata0, 32'h55);
    d_we0 = 1'b0;
    step();
    check_eq("coll_instr_new", i_rdata0, 32'hCAFEBABE);
    check_eq("coll_data_hold", d_rdata0, 32'hCAFEBABE);

    // ---------------- aliasing ----------------
    d_addr0 = 32'h1003; i_addr0 = 32'h100C;
    step();
    check_eq("alias_data",     d_rdata0, 32'h11);
    check_eq("alias_instr",    i_rdata0, 32'h44);

`ifdef CORE_MEMORY_BYTE_STROBE_EN
    // ---------------- byte strobes ----------------
    d_we0 = 1'b1; d_addr0 = 32'h20; d_wdata0 = 32'h11223344; d_be0 = 4'hF;
    step();
    check_eq("be_full",        d_rdata0, 32'h11223344);
    d_wdata0 = 32'hAABBCCDD; d_be0 = 4'b0101;
    step();
    check_eq("be_merge_fwd",   d_rdata0, 32'h11BB33DD);
    d_wdata0 = 32'hFFFFFFFF; d_be0 = 4'b0000;
    step();
    check_eq("be_none_fwd",    d_rdata0, 32'h11BB33DD);
    d_we0 = 1'b0; d_be0 = 4'hF;
    step();
    check_eq("be_readback",    d_rdata0, 32'h11BB33DD);
`endif

    // ---------------- reset mid-RUN ----------------
    rst0_n = 1'b0; d_we0 = 1'b1; d_addr0 = 32'h8; d_wdata0 = 32'hEEEEEEEE;
    step();
    d_we0 = 1'b0;
    check_eq("midrst_run",     {31'b0, run0},     32'h0);
    check_eq("midrst_ready",   {31'b0, l_ready0}, 32'h0);
    check_eq("midrst_instr",   i_rdata0,          NOP);
    check_eq("midrst_data",    d_rdata0,          32'h0);
    rst0_n = 1'b1;
    step();
    check_eq("reload_ready",   {31'b0, l_ready0}, 32'h1);
    l_valid0 = 1'b1; l_data0 = 32'h99; l_last0 = 1'b1;
    step();
    l_valid0 = 1'b0; l_last0 = 1'b0;
    check_eq("reload_run",     {31'b0, run0}, 32'h1);
    i_addr0 = 32'h4; d_addr0 = 32'h0;
    step();
    check_eq("reload_word0",   d_rdata0, 32'h99);
    check_eq("retain_word1",   i_rdata0, 32'h22);
    d_addr0 = 32'h8;
    step();
    check_eq("retain_word2",   d_rdata0, 32'h33);

    // ---------------- depth-4 instance: full-array exit ----------------
    rst1_n = 1'b1;
    step();
    check_eq("d4_ready",       {31'b0, l_ready1}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      l_valid1 = 1'b1; l_data1 = boot1[i]; l_last1 = 1'b0;
      step();
      if (i == 2) check_eq("d4_not_full", {31'b0, run1}, 32'h0);
    end
    check_eq("d4_full_run",    {31'b0, run1},     32'h1);
    check_eq("d4_full_ready",  {31'b0, l_ready1}, 32'h0);
    l_data1 = 32'hFF;
    step(); step();
    l_valid1 = 1'b0;
    check_eq("d4_ign_ready",   {31'b0, l_ready1}, 32'h0);
    d_addr1 = 32'h0; i_addr1 = 32'hC;
    step();
    check_eq("d4_word0",       d_rdata1, 32'hA0);
    check_eq("d4_word3",       i_rdata1, 32'hA3);
    d_addr1 = 32'h18;
    step();
    check_eq("d4_alias",       d_rdata1, 32'hA2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
